// File: rtl/axi_lite_master_pkg.sv
// Shared definitions for the AXI-Lite master: response codes and FSM states.
package axi_lite_master_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE_ADDR_DATA,
    ST_WRITE_RESP,
    ST_READ_ADDR,
    ST_READ_DATA,
    ST_RESPOND
  } state_t;

endpackage

// File: rtl/axi_lite_timeout.sv
// Watchdog counter: expire_o fires on the TIMEOUT_CYCLES-th enabled cycle since clear.
module axi_lite_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clear_i, enable_i};
    assign expire_o      = 1'b0;
  end else begin : g_on
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;

    assign expire_o = enable_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
      if (rst || clear_i) begin
        cnt_q <= '0;
      end else if (enable_i && !expire_o) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator driven by a valid/ready command port,
// with a one-cycle response strobe and an optional watchdog abort.
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_data,
  input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
  output logic                    o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_timeout,
  output logic                    o_awvalid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  input  logic                    i_awready,
  output logic                    o_wvalid,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_wready,
  input  logic                    i_bvalid,
  input  logic [1:0]              i_bresp,
  output logic                    o_bready,
  output logic                    o_arvalid,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_arready,
  input  logic                    i_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp,
  output logic                    o_rready
);

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                    wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  logic wd_enable, wd_expire;
  logic aw_ok, w_ok;

  assign wd_enable = (state_q != ST_IDLE) && (state_q != ST_RESPOND);

  axi_lite_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!wd_enable),
    .enable_i (wd_enable),
    .expire_o (wd_expire)
  );

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_ok = !awvalid_q || i_awready;
  assign w_ok  = !wvalid_q  || i_wready;

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    awaddr_d      = awaddr_q;
    wvalid_d      = wvalid_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    araddr_d      = araddr_q;
    rready_d      = rready_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (i_cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (i_cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            awaddr_d  = i_cmd_addr;
            wdata_d   = i_cmd_data;
            wstrb_d   = i_cmd_strb;
            state_d   = ST_WRITE_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            araddr_d  = i_cmd_addr;
            state_d   = ST_READ_ADDR;
          end
        end
      end
      ST_WRITE_ADDR_DATA: begin
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_wready)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          state_d = ST_WRITE_RESP;
          if (i_bvalid) begin
            bready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_data_d    = '0;
            rsp_resp_d    = i_bresp;
            rsp_timeout_d = 1'b0;
            state_d       = ST_RESPOND;
          end
        end
      end
      ST_WRITE_RESP: begin
        if (i_bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_resp_d    = i_bresp;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESPOND;
        end
      end
      ST_READ_ADDR: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_READ_DATA;
          if (i_rvalid) begin
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_data_d    = i_rdata;
            rsp_resp_d    = i_rresp;
            rsp_timeout_d = 1'b0;
            state_d       = ST_RESPOND;
          end
        end
      end
      ST_READ_DATA: begin
        if (i_rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = i_rdata;
          rsp_resp_d    = i_rresp;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog abort overrides whatever the channel logic decided this cycle.
    if (wd_expire) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_data_d    = '0;
      rsp_resp_d    = AXI_RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = ST_RESPOND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      wvalid_q      <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= AXI_RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      wvalid_q      <= wvalid_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_awvalid     = awvalid_q;
  assign o_awaddr      = awaddr_q;
  assign o_wvalid      = wvalid_q;
  assign o_wdata       = wdata_q;
  assign o_wstrb       = wstrb_q;
  assign o_bready      = bready_q;
  assign o_arvalid     = arvalid_q;
  assign o_araddr      = araddr_q;
  assign o_rready      = rready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_rsp_timeout = rsp_timeout_q;

endmodule
